// File: rtl/lm32_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lm32_interrupt_ctrl
// Purpose  : Parametrised LM32 interrupt controller. Handles 1-32 active-low
//            pins, each with a two-flop synchroniser. Channels can be level or
//            falling-edge triggered. A fixed-priority encoder picks the lowest
//            pending, unmasked channel. Provides the IE/IM/IP/IT/IV CSRs.
// Config   : CFG_INTERRUPT_EDGE_EN - when defined, adds the IT register and
//            the s3 stage so that each channel can be edge triggered. When
//            undefined, every channel is level sensitive and IT reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module lm32_interrupt_ctrl #(
  parameter int INTERRUPTS = 32,
  parameter int VEC_W      = (INTERRUPTS > 1) ? $clog2(INTERRUPTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [INTERRUPTS-1:0] interrupt_n,
  input  logic                  stall_x,
  input  logic                  non_debug_exception,
  input  logic                  debug_exception,
  input  logic                  eret_q_x,
  input  logic                  bret_q_x,
  input  logic [4:0]            csr,
  input  logic [31:0]           csr_write_data,
  input  logic                  csr_write_enable,
  output logic                  interrupt_exception,
  output logic [VEC_W-1:0]      interrupt_vector,
  output logic [31:0]           csr_read_data
);

  localparam logic [4:0] CSR_IE = 5'h00;
  localparam logic [4:0] CSR_IM = 5'h01;
  localparam logic [4:0] CSR_IP = 5'h02;
  localparam logic [4:0] CSR_IT = 5'h0C;
  localparam logic [4:0] CSR_IV = 5'h0D;

  logic                  ie;
  logic                  eie;
  logic                  bie;
  logic [INTERRUPTS-1:0] im;
  logic [INTERRUPTS-1:0] ip;
  logic [INTERRUPTS-1:0] s1;
  logic [INTERRUPTS-1:0] s2;
  logic [INTERRUPTS-1:0] evt;
  logic [INTERRUPTS-1:0] clr;
  logic [INTERRUPTS-1:0] pend;
  logic [INTERRUPTS-1:0] wdata;
  logic                  csr_accept;
  logic                  valid;
  logic                  unused_wdata;

  // A wcsr only lands when no exception, eret or bret claims this cycle
  assign csr_accept = csr_write_enable & ~stall_x & ~non_debug_exception &
                      ~debug_exception & ~eret_q_x & ~bret_q_x;

  // Bits at or above INTERRUPTS are dropped
  assign wdata        = csr_write_data[INTERRUPTS-1:0];
  assign unused_wdata = &{1'b0, csr_write_data};

  assign clr = (csr_accept && (csr == CSR_IP)) ? wdata : '0;

`ifdef CFG_INTERRUPT_EDGE_EN
  logic [INTERRUPTS-1:0] it;
  logic [INTERRUPTS-1:0] s3;

  // Three-stage pin pipeline: s1/s2 synchronise, s3 holds the previous level
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= interrupt_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Trigger select register, written only by an accepted wcsr
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      it <= '0;
    end else if (csr_accept && (csr == CSR_IT)) begin
      it <= wdata;
    end
  end

  // Edge channels pulse once on high-to-low; level channels follow the pin
  assign evt = (it & s3 & ~s2) | (~it & ~s2);
`else
  // Two-stage pin synchroniser
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= interrupt_n;
      s2 <= s1;
    end
  end

  assign evt = ~s2;
`endif

  // Pending bits: W1C clear, but a new event always wins so none is lost
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ip <= '0;
    end else begin
      ip <= (ip & ~clr) | evt;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      im <= '0;
    end else if (csr_accept && (csr == CSR_IM)) begin
      im <= wdata;
    end
  end

  // Enable chain: exceptions save ie, eret/bret restore it, then wcsr
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ie  <= 1'b0;
      eie <= 1'b0;
      bie <= 1'b0;
    end else if (non_debug_exception) begin
      eie <= ie;
      ie  <= 1'b0;
    end else if (debug_exception) begin
      bie <= ie;
      ie  <= 1'b0;
    end else if (!stall_x) begin
      if (eret_q_x) begin
        ie <= eie;
      end else if (bret_q_x) begin
        ie <= bie;
      end else if (csr_accept && (csr == CSR_IE)) begin
        ie  <= csr_write_data[0];
        eie <= csr_write_data[1];
        bie <= csr_write_data[2];
      end
    end
  end

  assign pend                = ip & im;
  assign valid               = |pend;
  assign interrupt_exception = ie & valid;

  // Fixed priority: scanning downwards leaves the lowest set index
  always_comb begin
    interrupt_vector = '0;
    for (int i = INTERRUPTS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        interrupt_vector = VEC_W'(i);
      end
    end
  end

  // CSR read mux; unmapped indices read zero
  always_comb begin
    csr_read_data = 32'h0;
    case (csr)
      CSR_IE: csr_read_data = {29'h0, bie, eie, ie};
      CSR_IM: csr_read_data = 32'(im);
      CSR_IP: csr_read_data = 32'(ip);
`ifdef CFG_INTERRUPT_EDGE_EN
      CSR_IT: csr_read_data = 32'(it);
`else
      CSR_IT: csr_read_data = 32'h0;
`endif
      CSR_IV: csr_read_data = {valid, 26'h0, 5'(interrupt_vector)};
      default: csr_read_data = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lm32_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lm32_interrupt_ctrl
// Purpose  : Directed self-checking bench for lm32_interrupt_ctrl, with a
//            32-channel instance and a 1-channel instance for width checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lm32_interrupt_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pins;
  logic [0:0]  pin1;
  logic        stall_x;
  logic        ndx;
  logic        dbg;
  logic        eret;
  logic        bret;
  logic [4:0]  csr;
  logic [31:0] wdata;
  logic        we;
  logic        exc;
  logic [4:0]  vec;
  logic [31:0] rdata;
  logic        exc1;
  logic [0:0]  vec1;
  logic [31:0] rdata1;

  int n_vec = 0;
  int n_err = 0;

  lm32_interrupt_ctrl #(.INTERRUPTS(32)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .interrupt_n         (pins),
    .stall_x             (stall_x),
    .non_debug_exception (ndx),
    .debug_exception     (dbg),
    .eret_q_x            (eret),
    .bret_q_x            (bret),
    .csr                 (csr),
    .csr_write_data      (wdata),
    .csr_write_enable    (we),
    .interrupt_exception (exc),
    .interrupt_vector    (vec),
    .csr_read_data       (rdata)
  );

  lm32_interrupt_ctrl #(.INTERRUPTS(1)) dut1 (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .interrupt_n         (pin1),
    .stall_x             (stall_x),
    .non_debug_exception (ndx),
    .debug_exception     (dbg),
    .eret_q_x            (eret),
    .bret_q_x            (bret),
    .csr                 (csr),
    .csr_write_data      (wdata),
    .csr_write_enable    (we),
    .interrupt_exception (exc1),
    .interrupt_vector    (vec1),
    .csr_read_data       (rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    csr = idx;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic rd1(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    csr = idx;
    #1;
    check(tag, rdata1, exp);
  endtask

  task automatic wcsr(input logic [4:0] idx, input logic [31:0] d);
    csr   = idx;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pins = '1; pin1 = 1'b1;
    stall_x = 1'b0; ndx = 1'b0; dbg = 1'b0; eret = 1'b0; bret = 1'b0;
    csr = 5'h0; wdata = 32'h0; we = 1'b0;

    // Reset state
    cyc(2);
    check("rst_exc", {31'h0, exc}, 32'h0);
    check("rst_vec", {27'h0, vec}, 32'h0);
    rd(5'h00, 32'h0, "rst_ie");
    rd(5'h02, 32'h0, "rst_ip");
    rst_n = 1'b1;
    cyc(1);

    // Level path and pin-to-exception latency
    wcsr(5'h01, 32'h5);
    wcsr(5'h00, 32'h1);
    pins[2] = 1'b0;
    cyc(2);
    check("lat_early", {31'h0, exc}, 32'h0);
    cyc(1);
    check("lat_exc", {31'h0, exc}, 32'h1);
    check("lat_vec", {27'h0, vec}, 32'h2);
    rd(5'h0D, 32'h8000_0002, "iv_read");
    wcsr(5'h02, 32'h4);
    rd(5'h02, 32'h4, "lvl_noclr_held");
    pins[2] = 1'b1;
    cyc(3);
    wcsr(5'h02, 32'h4);
    rd(5'h02, 32'h0, "lvl_clr");
    check("lvl_exc_off", {31'h0, exc}, 32'h0);
    rd(5'h1F, 32'h0, "unmapped");

    // Priority encoder
    wcsr(5'h01, 32'hFF);
    pins[7] = 1'b0;
    pins[3] = 1'b0;
    cyc(3);
    check("prio_3", {27'h0, vec}, 32'h3);
    pins[3] = 1'b1;
    cyc(3);
    wcsr(5'h02, 32'h8);
    check("prio_7", {27'h0, vec}, 32'h7);
    rd(5'h02, 32'h80, "prio_ip");
    pins[7] = 1'b1;
    cyc(3);
    wcsr(5'h02, 32'hFF);
    rd(5'h02, 32'h0, "prio_clr");

    // Enable chain
    ndx = 1'b1;
    cyc(1);
    ndx = 1'b0;
    rd(5'h00, 32'h2, "ndx_ie");
    stall_x = 1'b1; eret = 1'b1;
    cyc(1);
    stall_x = 1'b0; eret = 1'b0;
    rd(5'h00, 32'h2, "eret_stalled");
    eret = 1'b1;
    cyc(1);
    eret = 1'b0;
    rd(5'h00, 32'h3, "eret_ie");

    // Debug exception beats a same-cycle IE write
    dbg = 1'b1; csr = 5'h00; wdata = 32'h1; we = 1'b1;
    cyc(1);
    dbg = 1'b0; we = 1'b0;
    rd(5'h00, 32'h6, "dbg_prec");
    bret = 1'b1;
    cyc(1);
    bret = 1'b0;
    rd(5'h00, 32'h7, "bret_ie");

    // IP clear is dropped in a cycle taken by eret
    pins[5] = 1'b0;
    cyc(3);
    pins[5] = 1'b1;
    cyc(3);
    eret = 1'b1; csr = 5'h02; wdata = 32'h20; we = 1'b1;
    cyc(1);
    eret = 1'b0; we = 1'b0;
    rd(5'h02, 32'h20, "ipclr_eret");
    wcsr(5'h02, 32'h20);
    rd(5'h02, 32'h0, "ipclr_ok");

`ifdef CFG_INTERRUPT_EDGE_EN
    // Edge mode
    wcsr(5'h0C, 32'h1);
    rd(5'h0C, 32'h1, "it_read");
    pins[0] = 1'b0;
    cyc(4);
    pins[0] = 1'b1;
    cyc(4);
    rd(5'h02, 32'h1, "edge_sticky");
    wcsr(5'h02, 32'h1);
    rd(5'h02, 32'h0, "edge_clr");
    pins[0] = 1'b0;
    cyc(4);
    wcsr(5'h02, 32'h1);
    rd(5'h02, 32'h0, "edge_clr_held");
    pins[0] = 1'b1;
    cyc(3);
    pins[0] = 1'b0;
    cyc(2);
    csr = 5'h02; wdata = 32'h1; we = 1'b1;
    cyc(1);
    we = 1'b0;
    rd(5'h02, 32'h1, "edge_set_wins");
    wcsr(5'h0C, 32'h0);
    rd(5'h02, 32'h1, "it_keeps_ip");
    pins[0] = 1'b1;
    cyc(3);
    wcsr(5'h02, 32'h1);
    rd(5'h02, 32'h0, "edge_final_clr");
`else
    wcsr(5'h0C, 32'h1);
    rd(5'h0C, 32'h0, "it_absent");
`endif

    // Single-channel instance
    wcsr(5'h01, 32'hFFFF_FFFF);
    rd1(5'h01, 32'h1, "w1_im");
    pin1 = 1'b0;
    cyc(3);
    check("w1_exc", {31'h0, exc1}, 32'h1);
    check("w1_vec", {31'h0, vec1}, 32'h0);
    rd1(5'h0D, 32'h8000_0000, "w1_iv");

    // Asynchronous reset mid-operation
    pins[4] = 1'b0;
    cyc(3);
    check("mid_exc_on", {31'h0, exc}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_exc_off", {31'h0, exc}, 32'h0);
    rd(5'h00, 32'h0, "mid_ie");
    rd(5'h01, 32'h0, "mid_im");
    rst_n = 1'b1;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lm32_interrupt_ctrl.md
# lm32_interrupt_ctrl

Parametrised interrupt controller for the LM32 core. It replaces the fixed interrupt unit and supports 1–32 active-low interrupt pins, each with a two-flop input synchroniser. Each channel is individually selectable as level- or falling-edge-triggered. A fixed-priority encoder drives the vector for the highest-priority pending, unmasked channel. It sits beside the pipeline's CSR file, takes exception, eret and bret events from the X stage, and raises `interrupt_exception` to the exception logic.

## Interface
Parameters:
- `INTERRUPTS`, default 32: number of channels, legal range 1–32.
- `VEC_W`, default 5: vector width, max(1, clog2(`INTERRUPTS`)).

Ports:
- `clk_i`, in, 1: clock.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `interrupt_n`, in, `INTERRUPTS`: interrupt pins, active-low, asynchronous to `clk_i`.
- `stall_x`, in, 1: X stage stalled.
- `non_debug_exception`, in, 1: non-debug exception raised this cycle.
- `debug_exception`, in, 1: debug exception raised this cycle.
- `eret_q_x`, in, 1: eret in X, qualified.
- `bret_q_x`, in, 1: bret in X, qualified.
- `csr`, in, 5: CSR index.
- `csr_write_data`, in, 32: wcsr data.
- `csr_write_enable`, in, 1: wcsr strobe.
- `interrupt_exception`, out, 1: request interrupt exception.
- `interrupt_vector`, out, `VEC_W`: lowest-index pending and unmasked channel.
- `csr_read_data`, out, 32: rcsr data.

## Operation
- CSR map:
  - IE=0x00: bit0 ie, bit1 eie, bit2 bie.
  - IM=0x01: mask.
  - IP=0x02: pending, write-1-to-clear.
  - IT=0x0C: trigger, 1=edge.
  - IV=0x0D: read-only, {valid, 26'b0, vector zero-extended to 5 bits}.
- Synchroniser: s1 <= `interrupt_n`; s2 <= s1; s3 <= s2.
- Event per channel:
  - Level: event = ~s2.
  - Edge: event = s3 & ~s2, a one-cycle pulse per falling edge.
- Pending update every cycle: ip <= (ip & ~clr) | event.
  - clr = `csr_write_data`[INTERRUPTS-1:0] when the IP write is accepted, else 0.
  - Set wins over clear in the same cycle, so edges are never lost.
  - A level channel cannot be cleared while its pin is held low.
- Enable state, in priority order, evaluated each cycle:
  1. `non_debug_exception`: eie <= ie; ie <= 0.
  2. Else `debug_exception`: bie <= ie; ie <= 0.
  3. Else if !`stall_x`, `eret_q_x`: ie <= eie.
  4. Else if !`stall_x`, `bret_q_x`: ie <= bie.
  5. Else if !`stall_x`, `csr_write_enable`: the write to IE/IM/IP/IT is accepted.
  - CSR writes are accepted only at step 5. An IP clear is ignored in any cycle taken by steps 1–4.
- `interrupt_exception` = ie & |(ip & im), combinational from registers only.
- `interrupt_vector`: index of the lowest set bit of ip & im. It is 0 when none is set, and is valid only when valid = |(ip & im).
- Bits of `csr_write_data` at or above `INTERRUPTS` are ignored. CSR reads zero-extend IM, IP and IT.
- Unmapped CSR indices read 0.
- `csr_read_data` is combinational from `csr`.

## Timing
- Reset values:
  - ie, eie, bie, im, ip, it all 0.
  - s1, s2, s3 all 1.
  - `interrupt_exception` = 0; `interrupt_vector` = 0; `csr_read_data` reads CSR 0 as 0.
- Latency, pin low to ip visible:
  - Pin low set up before edge N: s1 at N, s2 at N+1, ip at N+2.
  - `interrupt_exception` is high in the cycle after edge N+2, if enabled and unmasked.
- Edge mode detects a pin only if it stays low for at least 2 clocks; shorter pulses may be missed.
- Writes to IE, IM and IT take effect at the accepting edge. `interrupt_exception` reflects the write in the next cycle.
- Switching a channel's IT bit does not clear its ip; only a W1C write to IP does.
- Reset mid-operation: all state returns to reset values asynchronously. Reset deassertion is synchronised by the instantiating level.

## Configuration
- `CFG_INTERRUPT_EDGE_EN` defined:
  - The IT register and s3 stage exist.
  - Each channel follows its IT bit.
- Undefined:
  - No IT register and no s3 stage; every channel is level-sensitive.
  - CSR 0x0C reads 0 and writes to it are ignored.
  - All other behaviour is unchanged.

## Test plan
- Level path: reset, write IM=0x5, IE=0x1, then drive `interrupt_n`[2] low → `interrupt_exception`=1 three cycles later, `interrupt_vector`=2, IV reads 0x80000002.
- Priority: pins 7 and 3 low with IM=0xFF → vector=3. Release pin 3 and write IP=0x8 → vector=7.
- Edge mode (macro on): write IT=0x1, then pulse `interrupt_n`[0] low for 4 cycles → ip[0] stays 1 after release. A W1C write of IP=0x1 clears it. A new edge arriving in the same cycle as the clear leaves ip[0]=1.
- Enable chain: ie=1, then `non_debug_exception` → IE reads 0x2. `eret_q_x` with stall_x=0 → IE reads 0x3. With `stall_x`=1, eret is ignored.
- Precedence: `debug_exception` together with a wcsr write of IE=0x1 in the same cycle → bie=old ie, ie=0, write dropped.
- Width: `INTERRUPTS`=1 → `VEC_W`=1 and upper write bits ignored. Write IM=0xFFFFFFFF → IM reads 0x1.
